// File: rtl/aes_pkg.sv
// AES-128 constants and helpers shared by the key schedule.
// Holds the round count, the round-constant table, the S-box, the FSM
// state encodings and the 128/32-bit word types.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] word128_t;
    typedef logic [31:0]  word32_t;
    typedef logic [1:0]   state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t EXPAND = 2'd1;
    localparam state_t SERVE  = 2'd2;

    // Indexed by round number 1..10.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rounds outside 1..10 yield zero so an idle counter never reads off the table.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Key-in / round-key-out bundle of the inverse key schedule.
//   key_valid/key_in/key_ready : cipher key handshake (master -> slave)
//   rkey_take                  : consumer accepted the current round key
//   rkey_valid/rkey_out/rkey_idx/done : round key stream (slave -> master)
interface inv_key_schedule_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rkey_take;
    logic         rkey_valid;
    logic [127:0] rkey_out;
    logic [3:0]   rkey_idx;
    logic         done;

    modport master (
        output key_valid, key_in, rkey_take,
        input  key_ready, rkey_valid, rkey_out, rkey_idx, done
    );

    modport slave (
        input  key_valid, key_in, rkey_take,
        output key_ready, rkey_valid, rkey_out, rkey_idx, done
    );
endinterface

// File: rtl/key_expand_step.sv
// One combinational AES-128 key expansion round.
//   rk_in  : previous round key, w0 in bits [127:96]
//   rcon   : round constant for the round being produced
//   rk_out : next round key
module key_expand_step
    import aes_pkg::*;
(
    input  word128_t   rk_in,
    input  logic [7:0] rcon,
    output word128_t   rk_out
);

    word32_t w0, w1, w2, w3;
    word32_t rot, sub, temp;
    word32_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub[8*i +: 8] = sub_byte(rot[8*i +: 8]);
    end

    assign temp = sub ^ {rcon, 24'h0};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 key schedule feeding the inverse rounds: expands one
// round key per cycle into local storage, then streams them out from
// round 10 down to round 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key input and round key output bundle (slave side)
//
// state  | meaning
// IDLE   | key_ready high, waiting for a cipher key
// EXPAND | writing rk[cnt] each cycle, cnt = 1..10
// SERVE  | presenting rk[rkey_idx] until round 0 is taken
module inv_key_schedule #(
    parameter int NR = aes_pkg::NR
) (
    input  logic             clk,
    input  logic             rst_n,
    inv_key_schedule_if.slave bus
);
    import aes_pkg::*;

    state_t     state;
    logic [3:0] cnt;
    word128_t   rk [0:NR];
    word128_t   exp_in;
    word128_t   exp_out;
    logic [7:0] rcon_cur;

    // cnt is 0 outside EXPAND; keep the read index in range there.
    assign exp_in   = (cnt == 4'd0) ? rk[0] : rk[cnt - 4'd1];
    assign rcon_cur = rcon_of(cnt);

    key_expand_step u_step (
        .rk_in  (exp_in),
        .rcon   (rcon_cur),
        .rk_out (exp_out)
    );

    assign bus.key_ready = (state == IDLE);

    // Plain registers, no reset: contents only matter after a full expansion.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.key_valid) begin
            rk[0] <= bus.key_in;
        end else if (state == EXPAND) begin
            rk[cnt] <= exp_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.rkey_valid <= 1'b0;
            bus.rkey_out   <= '0;
            bus.rkey_idx   <= 4'd0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.key_valid) begin
                        state <= EXPAND;
                        cnt   <= 4'd1;
                    end
                end
                EXPAND: begin
                    if (cnt == 4'(NR)) begin
                        // rk[NR] is being written this edge, so forward it directly.
                        state          <= SERVE;
                        cnt            <= 4'd0;
                        bus.rkey_out   <= exp_out;
                        bus.rkey_idx   <= 4'(NR);
                        bus.rkey_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SERVE: begin
                    if (bus.rkey_take && bus.rkey_valid) begin
                        if (bus.rkey_idx != 4'd0) begin
                            bus.rkey_out <= rk[bus.rkey_idx - 4'd1];
                            bus.rkey_idx <= bus.rkey_idx - 4'd1;
                        end else begin
                            bus.rkey_valid <= 1'b0;
                            bus.done       <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    inv_key_schedule_if bus ();

    inv_key_schedule #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R6  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic reset_dut();
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rkey_take = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic offer_key(input logic [127:0] k);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.key_ready !== 1'b1 || bus.rkey_valid !== 1'b0 || bus.rkey_out !== '0 ||
            bus.rkey_idx !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b out=%h idx=%0d done=%b, need 1 0 0 0 0",
                     bus.key_ready, bus.rkey_valid, bus.rkey_out, bus.rkey_idx, bus.done);
        end
    endtask

    task automatic test_full_sequence();
        int lat;
        offer_key(K1_RK[0]);
        checks++;
        if (bus.key_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_low: got %b need 0", bus.key_ready);
        end
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL full_latency: got %0d need 10", lat);
        end
        bus.rkey_take = 1'b1;
        for (int k = 10; k >= 0; k--) begin
            checks++;
            if (bus.rkey_valid !== 1'b1 || bus.rkey_idx !== 4'(k) || bus.rkey_out !== K1_RK[k] ||
                bus.done !== 1'b0 || bus.key_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_key: valid=%b idx=%0d out=%h done=%b ready=%b, need 1 %0d %h 0 0",
                         bus.rkey_valid, bus.rkey_idx, bus.rkey_out, bus.done, bus.key_ready,
                         k, K1_RK[k]);
            end
            @(negedge clk);
        end
        bus.rkey_take = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.rkey_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_done: done=%b valid=%b ready=%b, need 1 0 1",
                     bus.done, bus.rkey_valid, bus.key_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: done=%b need 0", bus.done);
        end
    endtask

    task automatic test_stall();
        int lat;
        int n;
        offer_key(K2);
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 10 || bus.rkey_idx !== 4'd10 || bus.rkey_out !== K2_R10) begin
            errors++;
            $display("FAIL stall_first: lat=%0d idx=%0d out=%h, need 10 10 %h",
                     lat, bus.rkey_idx, bus.rkey_out, K2_R10);
        end
        bus.rkey_take = 1'b1;
        n = 0;
        while (bus.rkey_idx !== 4'd6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.rkey_take = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.rkey_valid !== 1'b1 || bus.rkey_idx !== 4'd6 || bus.rkey_out !== K2_R6) begin
                errors++;
                $display("FAIL stall_hold c%0d: valid=%b idx=%0d out=%h, need 1 6 %h",
                         c, bus.rkey_valid, bus.rkey_idx, bus.rkey_out, K2_R6);
            end
        end
        bus.rkey_take = 1'b1;
        n = 0;
        while (bus.rkey_idx !== 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rkey_valid !== 1'b1 || bus.rkey_out !== K2) begin
            errors++;
            $display("FAIL stall_idx0: valid=%b out=%h, need 1 %h", bus.rkey_valid, bus.rkey_out, K2);
        end
        @(negedge clk);
        bus.rkey_take = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done=%b need 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_key();
        int n;
        offer_key(K1_RK[0]);
        bus.key_valid = 1'b1;
        bus.key_in    = K2;
        n = 0;
        while (bus.rkey_valid !== 1'b1 && n < 40) begin
            checks++;
            if (bus.key_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_ready_expand: got %b need 0", bus.key_ready);
            end
            @(negedge clk);
            n++;
        end
        bus.rkey_take = 1'b1;
        for (int k = 10; k >= 1; k--) begin
            checks++;
            if (bus.rkey_idx !== 4'(k) || bus.rkey_out !== K1_RK[k] || bus.key_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_key: idx=%0d out=%h ready=%b, need %0d %h 0",
                         bus.rkey_idx, bus.rkey_out, bus.key_ready, k, K1_RK[k]);
            end
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
        checks++;
        if (bus.rkey_idx !== 4'd0 || bus.rkey_out !== K1_RK[0]) begin
            errors++;
            $display("FAIL ignore_idx0: idx=%0d out=%h, need 0 %h", bus.rkey_idx, bus.rkey_out, K1_RK[0]);
        end
        @(negedge clk);
        bus.rkey_take = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: done=%b need 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        // Reset at EXPAND cycle 4.
        offer_key(K2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.key_ready !== 1'b1 || bus.rkey_valid !== 1'b0 || bus.rkey_out !== '0 ||
            bus.rkey_idx !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_expand: ready=%b valid=%b out=%h idx=%0d done=%b, need 1 0 0 0 0",
                     bus.key_ready, bus.rkey_valid, bus.rkey_out, bus.rkey_idx, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset in SERVE, two keys in.
        offer_key(K2);
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.rkey_take = 1'b1;
        repeat (2) @(negedge clk);
        bus.rkey_take = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.key_ready !== 1'b1 || bus.rkey_valid !== 1'b0 || bus.rkey_out !== '0 ||
            bus.rkey_idx !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_serve: ready=%b valid=%b out=%h idx=%0d done=%b, need 1 0 0 0 0",
                     bus.key_ready, bus.rkey_valid, bus.rkey_out, bus.rkey_idx, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        offer_key(K1_RK[0]);
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL rst_fresh_latency: got %0d need 10", lat);
        end
        bus.rkey_take = 1'b1;
        for (int k = 10; k >= 0; k--) begin
            checks++;
            if (bus.rkey_idx !== 4'(k) || bus.rkey_out !== K1_RK[k]) begin
                errors++;
                $display("FAIL rst_fresh_key: idx=%0d out=%h, need %0d %h",
                         bus.rkey_idx, bus.rkey_out, k, K1_RK[k]);
            end
            @(negedge clk);
        end
        bus.rkey_take = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_done: done=%b need 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        offer_key(K1_RK[0]);
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        bus.rkey_take = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.rkey_take = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.key_ready !== 1'b1 || n != 11) begin
            errors++;
            $display("FAIL b2b_done: done=%b ready=%b takes=%0d, need 1 1 11", bus.done, bus.key_ready, n);
        end
        offer_key(K2);
        checks++;
        if (bus.key_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready=%b need 0", bus.key_ready);
        end
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 10 || bus.rkey_idx !== 4'd10 || bus.rkey_out !== K2_R10) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d idx=%0d out=%h, need 10 10 %h",
                     lat, bus.rkey_idx, bus.rkey_out, K2_R10);
        end
        bus.rkey_take = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.rkey_take = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_take_idle();
        int lat;
        int n;
        bus.rkey_take = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.rkey_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
                errors++;
                $display("FAIL take_idle c%0d: done=%b valid=%b ready=%b, need 0 0 1",
                         c, bus.done, bus.rkey_valid, bus.key_ready);
            end
        end
        offer_key(K2);
        lat = 0;
        while (bus.rkey_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL take_expand: done=%b need 0", bus.done);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 10 || bus.rkey_idx !== 4'd10 || bus.rkey_out !== K2_R10) begin
            errors++;
            $display("FAIL take_first: lat=%0d idx=%0d out=%h, need 10 10 %h",
                     lat, bus.rkey_idx, bus.rkey_out, K2_R10);
        end
        @(negedge clk);
        checks++;
        if (bus.rkey_idx !== 4'd9) begin
            errors++;
            $display("FAIL take_second: idx=%0d need 9", bus.rkey_idx);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.rkey_take = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL take_drain: cycles=%0d need 10", n);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_stall();
        test_ignore_key();
        test_reset_mid_run();
        test_back_to_back();
        test_take_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Iterative AES-128 key schedule for the decryption datapath. It sits directly upstream of the inverse round stage and drives that stage's 128-bit round key input. It accepts one cipher key, expands all 11 round keys forward at one round per cycle into local storage, then presents them in reverse order (round 10 down to round 0) under a valid/take handshake, which is the order the inverse rounds consume them.

## Interface

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  cipher key offered on key_in
- key_in  in  128  cipher key, byte 0 in bits [127:120]
- key_ready  out  1  block idle and able to accept a key
- rkey_take  in  1  consumer has taken the current round key
- rkey_valid  out  1  rkey_out/rkey_idx hold a valid round key
- rkey_out  out  128  round key, registered
- rkey_idx  out  4  round number of rkey_out (10..0)
- done  out  1  one-cycle pulse when round key 0 is taken

## Operation

- FSM states: IDLE, EXPAND, SERVE.
- IDLE: key_ready=1. On key_valid&&key_ready, store key_in as rk[0], set cnt=1, go to EXPAND.
- EXPAND: each cycle, rk[cnt] = key_expand_step(rk[cnt-1], RCON[cnt]); cnt increments. After writing rk[10], go to SERVE, load rkey_out=rk[10], rkey_idx=10, rkey_valid=1.
- key_expand_step: temp = SubWord(RotWord(w3)) ^ {RCON,24'h0}; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Words are 32-bit, w0 = bits [127:96].
- SERVE: on rkey_take && rkey_valid with rkey_idx>0, load rk[rkey_idx-1] and decrement rkey_idx. On take with rkey_idx==0: rkey_valid=0, done=1 for one cycle, go to IDLE.
- rkey_take while rkey_valid=0 is ignored. key_valid outside IDLE is ignored (key_ready=0); no key is queued.
- Storage rk[0..10] is retained after completion. It is overwritten only by the next expansion.

## Timing

- Reset values: key_ready=1, rkey_valid=0, rkey_out=0, rkey_idx=0, done=0; state=IDLE, cnt=0.
- Key accepted at edge T0. EXPAND occupies edges T1..T10. rkey_valid rises after edge T10 with idx 10, so the first key is 10 cycles after acceptance.
- One round key per cycle while rkey_take is held high. A full drain takes 11 cycles after the first valid.
- key_ready falls in the cycle after acceptance and returns high in the cycle after done.
- done and the rkey_valid fall happen on the same edge. The earliest next key acceptance is on the edge after that.
- Reset mid-EXPAND or mid-SERVE: all outputs return to reset values immediately. Partial storage contents are don't-care.

## Structure

- Shared package aes_pkg holds:
  - NR=10
  - RCON table (01,02,04,08,10,20,40,80,1B,36)
  - state enum {IDLE,EXPAND,SERVE}
  - 128-bit/32-bit word typedefs
- Sub-module key_expand_step: combinational, one round of expansion, with four S-box instances.
- Storage: 11x128 register array. Do not infer RAM; the read index changes every cycle.

## Test plan

- Key 2b7e151628aed2a6abf7158809cf4f3c, rkey_take held high -> idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at 10 cycles after acceptance, idx 1 = a0fafe1788542cb123a339392a6c7605, idx 0 = key, done pulse on the 11th take.
- Key 000102030405060708090a0b0c0d0e0f -> idx 10 = 13111d7fe3944a17f307a78b4d2b30c5. Stalling rkey_take for 5 cycles at idx 6 holds rkey_out and rkey_idx stable.
- key_valid pulsed with a different key during EXPAND and SERVE -> ignored, outputs still match the first key, key_ready=0 throughout.
- rst_n low at EXPAND cycle 4 -> all outputs at reset values. A fresh key afterwards yields the correct full sequence.
- Back-to-back: second key offered while done pulses -> accepted on the next edge, first valid of the second key 10 cycles later.
- rkey_take asserted in IDLE and during EXPAND -> no state change and no done.
